cam_capture_ctrl: RTL and testbench
===================================

Name: cam_capture_ctrl

Overview:
- Front-end capture stage for the OV7670-class parallel camera. It sits directly upstream of the DDR frame writer.
- Runs in the camera pixel clock domain. Assembles byte pairs into RGB565 pixels and emits exactly H_ACTIVE×V_ACTIVE `pixel_valid` strobes per frame.
- Drives a stretched `frame_done` pulse at end of frame, which the writer edge-detects in its 100 MHz domain to reset its DDR address offset.
- Flags malformed frames on `frame_err`.

Parameters:
- H_ACTIVE, 320, active pixels per line (bytes per line = 2×H_ACTIVE).
- V_ACTIVE, 240, active lines per frame.
- DONE_STRETCH, 4, pclk cycles `frame_done` is held high (must be ≥2).

Ports:
- pclk  in  1  camera pixel clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- capture_en  in  1  enables capture; sampled only at frame start.
- cam_vsync  in  1  camera VSYNC; high = vertical blanking.
- cam_href  in  1  camera HREF; high = active byte on cam_data.
- cam_data  in  8  camera data byte.
- pixel_data  out  16  RGB565 pixel; first byte of the pair = [15:8].
- pixel_valid  out  1  one-cycle strobe per pixel (writer FIFO wr_en).
- frame_done  out  1  end-of-frame pulse, DONE_STRETCH cycles wide.
- frame_err  out  1  sticky error for the current/last frame.
- frame_count  out  16  completed frames, wraps at 0xFFFF→0.

Behaviour:
- Clock and reset:
  - Single clock (pclk); reset is asynchronous and active-low (rst_n).
  - Reset values: pixel_data=0, pixel_valid=0, frame_done=0, frame_err=0, frame_count=0, state=WAIT_SOF, all counters 0, byte phase 0.
- Input stage: cam_vsync, cam_href and cam_data are registered once (stage 1). A vsync_d copy of the registered vsync provides edge detection. No metastability sync is needed because the inputs are pclk-synchronous.
- State machine:
  - WAIT_SOF: on the registered vsync falling edge, if capture_en=1 go to ACTIVE, clear x/y/phase/frame_err; otherwise stay.
  - ACTIVE: capture bytes. On the vsync rising edge go to DONE.
  - DONE: assert frame_done for DONE_STRETCH cycles, increment frame_count on entry, then go to WAIT_SOF.
  - A vsync falling edge arriving during DONE is ignored; that frame is skipped.
- Byte assembly (ACTIVE only):
  - Each href-high byte toggles the phase. Phase 0 latches the high byte. Phase 1 forms the pixel.
  - pixel_valid asserts the cycle after the stage-1 register holds the second byte, i.e. 2 pclk after the second byte is on the pins.
  - Pixel emitted only if x<H_ACTIVE and y<V_ACTIVE; x increments per pixel.
- Line end (registered href falling edge in ACTIVE):
  - If phase=1 (odd byte count) or x≠H_ACTIVE: set frame_err. No padding; the orphan byte is discarded.
  - Then x=0, phase=0, y=y+1 (saturating at V_ACTIVE).
- Excess data: lines with y≥V_ACTIVE and pixels with x≥H_ACTIVE are dropped and set frame_err.
- Frame end: at the vsync rising edge, if y≠V_ACTIVE set frame_err. frame_err holds until the next accepted SOF clears it.
- Mid-frame changes:
  - capture_en deassert mid-frame: the current frame completes normally.
  - capture_en assert mid-frame: no output until the next vsync falling edge.
- Reset mid-line: all outputs return to reset values immediately. After release the block waits for a full vsync falling edge; no partial frame is emitted.
- Width rules:
  - x width = $clog2(H_ACTIVE+1); y width = $clog2(V_ACTIVE+1).
  - The frame_done stretch counter is $clog2(DONE_STRETCH+1) bits.

Optional Feature:
- Macro: CAM_TEST_PATTERN_EN.
- When defined: adds input port `test_pattern` (1 bit).
  - When it is high, pixel_data is replaced by 8 vertical colour bars, each H_ACTIVE/8 pixels wide, in order white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - Timing, pixel_valid, frame_done and error logic are unchanged; camera bytes are still required to pace pixels.
- When undefined: no port, no pattern logic, and pixel_data always comes from the camera.

Decomposition:
- Shared package cam_capture_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults;
  - the state encoding (WAIT_SOF=0, ACTIVE=1, DONE=2);
  - the eight RGB565 bar constants.
- One natural sub-module, cam_test_pattern: combinational bar lookup from x, instantiated only under CAM_TEST_PATTERN_EN.

Test Plan:
1. capture_en=1, one clean 320×240 frame, bytes counting 0x00,0x01,…:
   - exactly 76800 pixel_valid strobes;
   - first pixel_data=0x0001, second=0x0203;
   - frame_done high for exactly 4 cycles after the vsync rise;
   - frame_count=1, frame_err=0.
2. capture_en raised mid-frame (line 100):
   - zero pixel_valid for that frame;
   - the next frame yields 76800 strobes, frame_count=1.
3. Line 5 carries 638 bytes:
   - that line gives 319 pixels, frame_err=1 after the line end;
   - the next clean frame clears frame_err to 0 at SOF.
4. Frame with 241 lines and one line of 641 bytes:
   - total strobes=76800, extra data dropped, frame_err=1.
5. rst_n low for 3 cycles at line 50 pixel 17:
   - all outputs 0 asynchronously;
   - no strobes until the next vsync fall;
   - the following frame gives 76800 strobes.
6. CAM_TEST_PATTERN_EN defined, test_pattern=1:
   - pixel x=0→0xFFFF, x=40→0xFFE0, x=319→0x0000;
   - 76800 strobes.

Source files
------------

// File: rtl/cam_capture_pkg.sv
// ----------------------------------------------------------------------------
// cam_capture_pkg
//
// Purpose: shared definitions for the camera capture front end.
//   - default active frame geometry (320x240, OV7670 QVGA)
//   - capture state encoding
//   - RGB565 constants for the optional colour-bar test pattern
//
// Ports: none (package).
// ----------------------------------------------------------------------------
package cam_capture_pkg;

    localparam int CAM_H_ACTIVE = 320;
    localparam int CAM_V_ACTIVE = 240;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        DONE     = 2'd2
    } cam_state_t;

    // Colour bars, left to right across the active line
    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

endpackage

// File: rtl/cam_test_pattern.sv
// ----------------------------------------------------------------------------
// cam_test_pattern
//
// Purpose: combinational lookup of an 8-bar vertical colour pattern from the
//   current pixel column. Each bar is H_ACTIVE/8 pixels wide.
//
// Ports:
//   x          in   XW  column of the pixel being formed (0..H_ACTIVE-1)
//   bar_pixel  out  16  RGB565 colour for that column
// ----------------------------------------------------------------------------
module cam_test_pattern
    import cam_capture_pkg::*;
#(
    parameter int H_ACTIVE = CAM_H_ACTIVE,
    parameter int XW       = $clog2(CAM_H_ACTIVE + 1)
) (
    input  logic [XW-1:0] x,
    output logic [15:0]   bar_pixel
);

    localparam logic [XW-1:0] BAR_W = XW'(H_ACTIVE / 8);

    logic [2:0] bar_sel;

    // Bar index is the column divided by the bar width; only columns below
    // H_ACTIVE are ever presented, so the index stays within 0..7.
    always_comb begin
        bar_sel = 3'(x / BAR_W);
        case (bar_sel)
            3'd0:    bar_pixel = BAR_WHITE;
            3'd1:    bar_pixel = BAR_YELLOW;
            3'd2:    bar_pixel = BAR_CYAN;
            3'd3:    bar_pixel = BAR_GREEN;
            3'd4:    bar_pixel = BAR_MAGENTA;
            3'd5:    bar_pixel = BAR_RED;
            3'd6:    bar_pixel = BAR_BLUE;
            default: bar_pixel = BAR_BLACK;
        endcase
    end

endmodule

// File: rtl/cam_capture_ctrl.sv
// ----------------------------------------------------------------------------
// cam_capture_ctrl
//
// Purpose: OV7670-class parallel camera capture stage. Pairs of bytes are
//   assembled into RGB565 pixels, exactly H_ACTIVE x V_ACTIVE pixel_valid
//   strobes are produced for a well-formed frame, a stretched frame_done
//   pulse marks end of frame for the downstream DDR writer, and malformed
//   frames raise a sticky frame_err.
//
// Optional build macro: CAM_TEST_PATTERN_EN adds the test_pattern input,
//   which substitutes 8 vertical colour bars for the camera pixel data.
//
// Ports:
//   pclk          in   1   camera pixel clock (only clock)
//   rst_n         in   1   asynchronous active-low reset
//   capture_en    in   1   capture enable, sampled at frame start
//   cam_vsync     in   1   VSYNC, high = vertical blanking
//   cam_href      in   1   HREF, high = active byte on cam_data
//   cam_data      in   8   camera data byte
//   test_pattern  in   1   colour-bar select (CAM_TEST_PATTERN_EN only)
//   pixel_data    out  16  RGB565 pixel, first byte of pair in [15:8]
//   pixel_valid   out  1   one-cycle strobe per pixel
//   frame_done    out  1   end-of-frame pulse, DONE_STRETCH cycles wide
//   frame_err     out  1   sticky error for the current/last frame
//   frame_count   out  16  completed frames, wrapping
// ----------------------------------------------------------------------------
module cam_capture_ctrl
    import cam_capture_pkg::*;
#(
    parameter int H_ACTIVE     = CAM_H_ACTIVE,
    parameter int V_ACTIVE     = CAM_V_ACTIVE,
    parameter int DONE_STRETCH = 4
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        capture_en,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
`ifdef CAM_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_count
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam int DW = $clog2(DONE_STRETCH + 1);

    localparam logic [XW-1:0] H_MAX     = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_MAX     = YW'(V_ACTIVE);
    localparam logic [DW-1:0] DONE_LOAD = DW'(DONE_STRETCH - 1);

    logic        vsync_r;
    logic        href_r;
    logic [7:0]  data_r;
    logic        vsync_d;
    logic        href_d;

    cam_state_t  state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic        phase;
    logic [7:0]  hi_byte;
    logic [DW-1:0] done_cnt;

    logic        vsync_fall;
    logic        vsync_rise;
    logic        href_fall;
    logic [15:0] next_pixel;

    // Camera outputs are launched on pclk, so a single register stage is
    // enough; the delayed copies give edge detection on the registered view.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            data_r  <= 8'h00;
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_r <= cam_vsync;
            href_r  <= cam_href;
            data_r  <= cam_data;
            vsync_d <= vsync_r;
            href_d  <= href_r;
        end
    end

    assign vsync_fall = vsync_d & ~vsync_r;
    assign vsync_rise = ~vsync_d & vsync_r;
    assign href_fall  = href_d & ~href_r;

`ifdef CAM_TEST_PATTERN_EN
    logic [15:0] bar_pixel;

    cam_test_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW)
    ) u_test_pattern (
        .x         (x),
        .bar_pixel (bar_pixel)
    );

    assign next_pixel = test_pattern ? bar_pixel : {hi_byte, data_r};
`else
    assign next_pixel = {hi_byte, data_r};
`endif

    // Capture state machine. Only a registered VSYNC falling edge with
    // capture enabled starts a frame, which keeps partial frames (after reset
    // or a late enable) out of the writer. Errors are sticky until the next
    // accepted start of frame.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_SOF;
            x           <= '0;
            y           <= '0;
            phase       <= 1'b0;
            hi_byte     <= 8'h00;
            done_cnt    <= '0;
            pixel_data  <= 16'h0000;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            pixel_valid <= 1'b0;
            case (state)
                WAIT_SOF: begin
                    if (vsync_fall && capture_en) begin
                        state     <= ACTIVE;
                        x         <= '0;
                        y         <= '0;
                        phase     <= 1'b0;
                        frame_err <= 1'b0;
                    end
                end

                ACTIVE: begin
                    if (vsync_rise) begin
                        state       <= DONE;
                        frame_done  <= 1'b1;
                        done_cnt    <= DONE_LOAD;
                        frame_count <= frame_count + 16'd1;
                        if (y != V_MAX) begin
                            frame_err <= 1'b1;
                        end
                    end else if (href_fall) begin
                        // An orphan byte or a short/long line marks the frame
                        // bad; the next line always restarts cleanly at x=0.
                        if (phase || (x != H_MAX)) begin
                            frame_err <= 1'b1;
                        end
                        x     <= '0;
                        phase <= 1'b0;
                        if (y != V_MAX) begin
                            y <= y + YW'(1);
                        end
                    end else if (href_r) begin
                        if (!phase) begin
                            hi_byte <= data_r;
                            phase   <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if ((x < H_MAX) && (y < V_MAX)) begin
                                pixel_data  <= next_pixel;
                                pixel_valid <= 1'b1;
                                x           <= x + XW'(1);
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                end

                DONE: begin
                    // VSYNC is deliberately not watched here, so a start of
                    // frame that lands inside the stretch is skipped.
                    if (done_cnt == '0) begin
                        frame_done <= 1'b0;
                        state      <= WAIT_SOF;
                    end else begin
                        done_cnt <= done_cnt - DW'(1);
                    end
                end

                default: begin
                    state <= WAIT_SOF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cam_capture_ctrl
//
// Purpose: directed self-checking bench for cam_capture_ctrl using a reduced
//   16x6 frame so each frame is a few hundred pclk cycles.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cam_capture_ctrl;

    localparam int H  = 16;
    localparam int V  = 6;
    localparam int DS = 4;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        capture_en = 1'b0;
    logic        cam_vsync = 1'b1;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
`ifdef CAM_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_count;

    int num_checks = 0;
    int num_fails  = 0;
    int strobes     = 0;
    int done_cycles = 0;
    int base;
    int dbase;
    int rst_mark = 0;
    logic [15:0] pix_log [0:2047];
    int   line_end [0:15];
    logic err_at   [0:15];

    cam_capture_ctrl #(
        .H_ACTIVE     (H),
        .V_ACTIVE     (V),
        .DONE_STRETCH (DS)
    ) dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .capture_en   (capture_en),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data     (cam_data),
`ifdef CAM_TEST_PATTERN_EN
        .test_pattern (test_pattern),
`endif
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .frame_count  (frame_count)
    );

    always #5 pclk = ~pclk;

    // Output monitor on the inactive edge: logs every pixel and counts
    // cycles with frame_done high.
    always @(negedge pclk) begin
        if (pixel_valid) begin
            if (strobes < 2048) begin
                pix_log[strobes] = pixel_data;
            end
            strobes = strobes + 1;
        end
        if (frame_done) begin
            done_cycles = done_cycles + 1;
        end
    end

    // Global time bound so the run always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one camera frame. Bytes count up from 0 across the frame.
    // odd_line gets odd_bytes bytes instead of 2*H; capture_en is raised at
    // the start of en_line; rst_n pulses for 3 cycles at rst_line/rst_pix.
    task automatic applyStimulus(input int n_lines, input int odd_line,
                                 input int odd_bytes, input int en_line,
                                 input int rst_line, input int rst_pix);
        logic [7:0] byte_val;
        int nb;
        byte_val = 8'h00;
        cam_vsync = 1'b1;
        repeat (3) @(negedge pclk);
        cam_vsync = 1'b0;
        repeat (4) @(negedge pclk);
        for (int ln = 0; ln < n_lines; ln++) begin
            if (ln == en_line) capture_en = 1'b1;
            nb = (ln == odd_line) ? odd_bytes : 2 * H;
            for (int b = 0; b < nb; b++) begin
                if (ln == rst_line && b == 2 * rst_pix) begin
                    rst_n = 1'b0;
                    #1;
                    checkOutput("rst_async_pixel_data", pixel_data, 16'h0000);
                    checkOutput("rst_async_pixel_valid", pixel_valid, 1'b0);
                    checkOutput("rst_async_frame_done", frame_done, 1'b0);
                    checkOutput("rst_async_frame_err", frame_err, 1'b0);
                    checkOutput("rst_async_frame_count", frame_count, 16'h0000);
                    repeat (3) @(negedge pclk);
                    rst_n = 1'b1;
                    rst_mark = strobes;
                end
                cam_href = 1'b1;
                cam_data = byte_val;
                byte_val = byte_val + 8'd1;
                @(negedge pclk);
            end
            cam_href = 1'b0;
            cam_data = 8'h00;
            repeat (5) @(negedge pclk);
            line_end[ln] = strobes;
            err_at[ln]   = frame_err;
        end
        repeat (2) @(negedge pclk);
        cam_vsync = 1'b1;
        repeat (12) @(negedge pclk);
    endtask

    initial begin
        $display("[TB] cam_capture_ctrl bench start, frame %0dx%0d", H, V);

        // Reset state
        repeat (3) @(negedge pclk);
        checkOutput("reset_pixel_data", pixel_data, 16'h0000);
        checkOutput("reset_pixel_valid", pixel_valid, 1'b0);
        checkOutput("reset_frame_done", frame_done, 1'b0);
        checkOutput("reset_frame_err", frame_err, 1'b0);
        checkOutput("reset_frame_count", frame_count, 16'h0000);
        rst_n = 1'b1;
        capture_en = 1'b1;
        repeat (2) @(negedge pclk);

        // 1: clean frame
        base = strobes; dbase = done_cycles;
        applyStimulus(V, -1, 0, -1, -1, 0);
        checkOutput("t1_strobes", strobes - base, H * V);
        checkOutput("t1_first_pixel", pix_log[base], 16'h0001);
        checkOutput("t1_second_pixel", pix_log[base + 1], 16'h0203);
        checkOutput("t1_line1_first_pixel", pix_log[base + H], 16'h2021);
        checkOutput("t1_last_pixel", pix_log[base + H * V - 1], 16'hBEBF);
        checkOutput("t1_done_cycles", done_cycles - dbase, DS);
        checkOutput("t1_frame_count", frame_count, 16'd1);
        checkOutput("t1_frame_err", frame_err, 1'b0);

        // 2: enable raised mid-frame, then a full frame
        capture_en = 1'b0;
        base = strobes; dbase = done_cycles;
        applyStimulus(V, -1, 0, 3, -1, 0);
        checkOutput("t2_late_en_strobes", strobes - base, 0);
        checkOutput("t2_late_en_done", done_cycles - dbase, 0);
        checkOutput("t2_late_en_count", frame_count, 16'd1);
        base = strobes;
        applyStimulus(V, -1, 0, -1, -1, 0);
        checkOutput("t2_next_strobes", strobes - base, H * V);
        checkOutput("t2_next_count", frame_count, 16'd2);

        // 3: line 2 short by two bytes
        base = strobes;
        applyStimulus(V, 2, 2 * H - 2, -1, -1, 0);
        checkOutput("t3_short_line_pixels", line_end[2] - line_end[1], H - 1);
        checkOutput("t3_err_before", err_at[1], 1'b0);
        checkOutput("t3_err_after", err_at[2], 1'b1);
        checkOutput("t3_line3_first_pixel", pix_log[base + 3 * H - 1], 16'h5E5F);
        checkOutput("t3_strobes", strobes - base, H * V - 1);
        checkOutput("t3_err_sticky", frame_err, 1'b1);
        applyStimulus(V, -1, 0, -1, -1, 0);
        checkOutput("t3_err_cleared_sof", err_at[0], 1'b0);
        checkOutput("t3_clean_err", frame_err, 1'b0);
        checkOutput("t3_clean_count", frame_count, 16'd4);

        // 4: extra line and one line of 2H+1 bytes
        base = strobes;
        applyStimulus(V + 1, 1, 2 * H + 1, -1, -1, 0);
        checkOutput("t4_long_line_pixels", line_end[1] - line_end[0], H);
        checkOutput("t4_err_line0", err_at[0], 1'b0);
        checkOutput("t4_err_line1", err_at[1], 1'b1);
        checkOutput("t4_extra_line_pixels", line_end[V] - line_end[V - 1], 0);
        checkOutput("t4_strobes", strobes - base, H * V);
        checkOutput("t4_frame_err", frame_err, 1'b1);
        checkOutput("t4_count", frame_count, 16'd5);

        // 5: reset at line 3 pixel 5
        base = strobes; dbase = done_cycles;
        applyStimulus(V, -1, 0, -1, 3, 5);
        checkOutput("t5_strobes_after_rst", strobes - rst_mark, 0);
        checkOutput("t5_done_after_rst", done_cycles - dbase, 0);
        checkOutput("t5_count_after_rst", frame_count, 16'd0);
        base = strobes;
        applyStimulus(V, -1, 0, -1, -1, 0);
        checkOutput("t5_next_strobes", strobes - base, H * V);
        checkOutput("t5_next_count", frame_count, 16'd1);
        checkOutput("t5_next_err", frame_err, 1'b0);

`ifdef CAM_TEST_PATTERN_EN
        // 6: colour bars (bar width H/8 = 2 pixels)
        test_pattern = 1'b1;
        base = strobes;
        applyStimulus(V, -1, 0, -1, -1, 0);
        test_pattern = 1'b0;
        checkOutput("t6_x0_white", pix_log[base], 16'hFFFF);
        checkOutput("t6_x2_yellow", pix_log[base + 2], 16'hFFE0);
        checkOutput("t6_x4_cyan", pix_log[base + 4], 16'h07FF);
        checkOutput("t6_x10_red", pix_log[base + 10], 16'hF800);
        checkOutput("t6_xlast_black", pix_log[base + H - 1], 16'h0000);
        checkOutput("t6_line1_x0_white", pix_log[base + H], 16'hFFFF);
        checkOutput("t6_strobes", strobes - base, H * V);
        checkOutput("t6_count", frame_count, 16'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
